// File: rtl/mem_stage.sv
// MEM stage and MEM/WB pipeline register: word-addressed data memory, SW/LW/LBU,
// write-back select, SYSCALL halt FSM, syscall display latch and retired counter.
module mem_stage #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] EXIT_CODE  = 32'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        go,
    input  logic [31:0] IRin,
    input  logic [31:0] PCin,
    input  logic        LBUin,
    input  logic        MemToRegin,
    input  logic        MemWritein,
    input  logic        RegWritein,
    input  logic        JALin,
    input  logic        SYSCALLin,
    input  logic [31:0] Result1in,
    input  logic [31:0] R1in,
    input  logic [31:0] R2in,
    input  logic [4:0]  W_numin,
    output logic [31:0] IRout,
    output logic [31:0] PCout,
    output logic        RegWriteout,
    output logic        SYSCALLout,
    output logic [4:0]  W_numout,
    output logic [31:0] WBdataout,
    output logic        halt,
    output logic [31:0] dispout,
    output logic [31:0] retired
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d, pc_q, pc_d, wbdata_q, wbdata_d;
    logic [31:0] disp_q, disp_d, retired_q, retired_d;
    logic        regwrite_q, regwrite_d, syscall_q, syscall_d;
    logic [4:0]  wnum_q, wnum_d;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           mem_rdata, load_data, wb_sel;
    logic [7:0]            byte_sel;
    logic                  mem_we;
    logic                  unused_bits;

    assign addr        = Result1in[ADDR_WIDTH+1:2];
    assign unused_bits = ^Result1in[31:ADDR_WIDTH+2];
    assign mem_rdata   = mem[addr];
    assign mem_we      = MemWritein & ~en & (state_q == RUN);

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (Result1in[1:0])
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        load_data = LBUin ? {24'd0, byte_sel} : mem_rdata;
        if (JALin)
            wb_sel = PCin + 32'd4;
        else if (MemToRegin)
            wb_sel = load_data;
        else
            wb_sel = Result1in;
    end

    // Read is combinational, so a load in the same cycle as a store sees the old word.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[addr] <= R2in;
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        pc_d       = pc_q;
        regwrite_d = regwrite_q;
        syscall_d  = syscall_q;
        wnum_d     = wnum_q;
        wbdata_d   = wbdata_q;
        disp_d     = disp_q;
        retired_d  = retired_q;
        if (!en) begin
            if (state_q == RUN) begin
                ir_d       = IRin;
                pc_d       = PCin;
                regwrite_d = RegWritein;
                syscall_d  = SYSCALLin;
                wnum_d     = W_numin;
                wbdata_d   = wb_sel;
                if (IRin != 32'd0)
                    retired_d = retired_q + 32'd1;
                if (SYSCALLin) begin
                    if (R1in == EXIT_CODE)
                        state_d = HALT;
                    else
                        disp_d = R2in;
                end
            end else begin
                // Halted: feed bubbles until go releases the machine.
                ir_d       = 32'd0;
                pc_d       = 32'd0;
                regwrite_d = 1'b0;
                syscall_d  = 1'b0;
                wnum_d     = 5'd0;
                wbdata_d   = 32'd0;
                if (go)
                    state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            ir_q       <= 32'd0;
            pc_q       <= 32'd0;
            regwrite_q <= 1'b0;
            syscall_q  <= 1'b0;
            wnum_q     <= 5'd0;
            wbdata_q   <= 32'd0;
            disp_q     <= 32'd0;
            retired_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            pc_q       <= pc_d;
            regwrite_q <= regwrite_d;
            syscall_q  <= syscall_d;
            wnum_q     <= wnum_d;
            wbdata_q   <= wbdata_d;
            disp_q     <= disp_d;
            retired_q  <= retired_d;
        end
    end

    assign IRout       = ir_q;
    assign PCout       = pc_q;
    assign RegWriteout = regwrite_q;
    assign SYSCALLout  = syscall_q;
    assign W_numout    = wnum_q;
    assign WBdataout   = wbdata_q;
    assign halt        = (state_q == HALT);
    assign dispout     = disp_q;
    assign retired     = retired_q;

endmodule
